// File: rtl/instruction_mem_param.sv
// instruction_mem_param
//   Parametrised instruction memory for the single-cycle core. Byte-addressed
//   fetch port (PC steps by 2) with a one-cycle registered read, a runtime
//   program loader, a power-up clear sequence and alignment/range flags.
//
//   Optional feature macro: INST_MEM_PARITY_EN
//     When defined, every stored word carries an even-parity bit computed on
//     write. An aligned, in-range fetch whose parity does not match raises
//     parity_err together with fetch_valid and returns NOP_WORD.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   fetch_req/addr      fetch request and byte address (sampled on posedge)
//   fetch_valid, inst   answer to the previous cycle's request
//   misalign            answered address had bit 0 set
//   out_of_range        answered word address >= DEPTH
//   ready               memory is in RUN and serving fetches
//   load_start          RUN: begin a load; LOAD: finish the load
//   load_wr, load_data  program word write strobe and data (LOAD only)
//   load_busy           high while clearing or loading
//   load_done           one-cycle pulse in the first RUN cycle after a load
//   parity_err          (INST_MEM_PARITY_EN only) stored parity mismatch
module instruction_mem_param #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 8,
  parameter int              DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] inst,
  output logic              misalign,
  output logic              out_of_range,
  output logic              ready,
  input  logic              load_start,
  input  logic              load_wr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic              load_done
`ifdef INST_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t            state, nstate;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              load_exit;

  logic [ADDR_W-2:0] waddr;
  logic [PTR_W-1:0]  ridx;
  logic              oor_c;

  logic              vld_p1;
  logic [DATA_W-1:0] inst_p1;
  logic              mis_p1;
  logic              oor_p1;

  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Load ends on an explicit stop or when the last word slot is written;
  // the pointer never wraps.
  assign load_exit = load_start || (load_wr && (ptr == LAST));

  // State register and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= nstate;
      load_done <= (state == S_LOAD) && (nstate == S_RUN);
      unique case (state)
        S_CLEAR: ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        S_RUN:   ptr <= '0;
        S_LOAD: begin
          if (load_exit)    ptr <= '0;
          else if (load_wr) ptr <= ptr + PTR_W'(1);
        end
        default: ptr <= '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_CLEAR: if (ptr == LAST) nstate = S_RUN;
      S_RUN:   if (load_start)  nstate = S_LOAD;
      S_LOAD:  if (load_exit)   nstate = S_RUN;
      default: nstate = S_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready     = (state == S_RUN);
    load_busy = (state == S_CLEAR) || (state == S_LOAD);
  end

  // Single write port shared by the clear sweep and the loader
  always_comb begin
    we    = (state == S_CLEAR) || ((state == S_LOAD) && load_wr);
    wdata = (state == S_CLEAR) ? NOP_WORD : load_data;
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= wdata;
  end

`ifdef INST_MEM_PARITY_EN
  logic mem_par [DEPTH];
  logic par_bad;
  logic perr_p1;

  always_ff @(posedge clk) begin
    if (we) mem_par[ptr] <= parity_f(wdata);
  end

  assign par_bad = (parity_f(mem[ridx]) != mem_par[ridx]);
`else
  logic par_bad;
  assign par_bad = 1'b0;
`endif

  assign waddr = fetch_addr[ADDR_W-1:1];
  assign ridx  = waddr[PTR_W-1:0];
  assign oor_c = (32'(waddr) >= 32'(DEPTH));

  // Stage p1: registered fetch answer, one cycle after the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      inst_p1 <= NOP_WORD;
      mis_p1  <= 1'b0;
      oor_p1  <= 1'b0;
    end else if ((state == S_RUN) && fetch_req) begin
      vld_p1  <= 1'b1;
      mis_p1  <= fetch_addr[0];
      oor_p1  <= oor_c;
      inst_p1 <= (fetch_addr[0] || oor_c || par_bad) ? NOP_WORD : mem[ridx];
    end else begin
      vld_p1  <= 1'b0;
      mis_p1  <= 1'b0;
      oor_p1  <= 1'b0;
    end
  end

`ifdef INST_MEM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_p1 <= 1'b0;
    else     perr_p1 <= (state == S_RUN) && fetch_req && !fetch_addr[0] && !oor_c && par_bad;
  end
  assign parity_err = perr_p1;
`endif

  assign fetch_valid  = vld_p1;
  assign inst         = inst_p1;
  assign misalign     = mis_p1;
  assign out_of_range = oor_p1;

endmodule
